regfile_c_wr: RTL

REGFILE_C_WR -- requirements
Module: regfile_c_wr

---
 rtl/regfile_c_wr.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_c_wr.sv
// Output bank for one result matrix: collects ROWS rows of N 32-bit lanes from the
// compute array under a valid/ready handshake and holds the bank for read-out.
module regfile_c_wr #(
    parameter int N    = 16,
    parameter int ROWS = 16,
    localparam int SW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       START,
    input  logic                       RES_VALID,
    input  logic [N-1:0][31:0]         RES_ROW,
    output logic                       RES_READY,
    output logic [ROWS*N-1:0][31:0]    OUT_DATA,
    output logic [SW-1:0]              SEQ_C,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       OVF_ERR
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [SW-1:0]       seq_q, seq_d;
    logic                ovf_q, ovf_d;
    logic                clr, wr_en;
    logic [N-1:0][31:0]  row_q [ROWS];

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        ovf_d   = ovf_q;
        clr     = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_COLLECT: begin
                // READY is constant in this state, so VALID alone is the handshake
                if (RES_VALID) begin
                    wr_en = 1'b1;
                    if (seq_q == SW'(ROWS - 1)) begin
                        seq_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        seq_d = seq_q + SW'(1);
                    end
                end
            end
            default: begin
                // START outranks a simultaneously offered row
                if (START) begin
                    clr     = 1'b1;
                    seq_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_COLLECT;
                end else if (RES_VALID) begin
                    ovf_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                row_q[gi] <= '0;
            end else if (clr) begin
                row_q[gi] <= '0;
            end else if (wr_en && (seq_q == SW'(gi))) begin
                row_q[gi] <= RES_ROW;
            end
        end
        assign OUT_DATA[gi*N +: N] = row_q[gi];
    end

    assign RES_READY = (state_q == S_COLLECT);
    assign BUSY      = (state_q == S_COLLECT);
    assign DONE      = (state_q == S_DONE);
    assign SEQ_C     = seq_q;
    assign OVF_ERR   = ovf_q;

endmodule
